// File: rtl/logcap_controller.sv
// rtl/logcap_controller.sv - probe capture engine: circular sample buffer, arm/trigger/post-trigger FSM, readback
// Driven by the command hub's opcode strobe and config registers; samples stream back one per READ_NEXT.
module logcap_controller #(
    parameter int         ADDR_W  = 10,
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] probe,
    input  logic       command_strobe,
    input  logic [7:0] command,
    input  logic [7:0] regOut0,
    input  logic [7:0] regOut1,
    input  logic [7:0] regOut2,
    input  logic [7:0] regOut3,
    input  logic [7:0] regOut4,
    input  logic [7:0] regOut5,
    input  logic [7:0] regOut6,
    input  logic [7:0] regOut7,
    output logic [7:0] regIn0,
    output logic [7:0] regIn1,
    output logic [7:0] regIn2,
    output logic [7:0] regIn3,
    output logic [7:0] regIn4,
    output logic [7:0] regIn5,
    output logic [7:0] regIn6,
    output logic [7:0] regIn7,
    output logic [7:0] status
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    localparam logic [7:0] CMD_ARM        = 8'h01;
    localparam logic [7:0] CMD_ABORT      = 8'h02;
    localparam logic [7:0] CMD_FORCE      = 8'h03;
    localparam logic [7:0] CMD_READ_NEXT  = 8'h04;
    localparam logic [7:0] CMD_RESET_READ = 8'h05;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_TRIG, S_DONE} state_t;

    state_t            state;
    logic [7:0]        p1, p2;
    logic [7:0]        trig_val, trig_mask, div_len, div_cnt;
    logic [15:0]       post_len, post_cnt;
    logic [ADDR_W-1:0] wr_ptr, trig_addr;
    logic [ADDR_W:0]   count, rd_ptr;
    logic              triggered, wrapped, read_valid, cmd_error, read_overrun;
    logic              force_pend, rd_pend;
    logic [7:0]        rd_data, ram_q;
    logic [7:0]        mem [DEPTH];

    logic              active, sample_en, restart, wr_en, hit, rd_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic              unused_regs;

    assign unused_regs = ^{regOut5, regOut6, regOut7};

    assign active    = (state == S_ARMED) || (state == S_TRIG);
    assign sample_en = active && (div_cnt == 8'd0);
    // ARM/ABORT in the same cycle as a sample pre-empt it, so nothing is written
    assign restart   = command_strobe && ((command == CMD_ARM) || (command == CMD_ABORT));
    assign wr_en     = sample_en && !restart;
    assign hit       = (((p2 ^ trig_val) & trig_mask) == 8'd0) || force_pend;
    assign rd_addr   = (wrapped ? wr_ptr : '0) + rd_ptr[ADDR_W-1:0];
    assign rd_ok     = command_strobe && (command == CMD_READ_NEXT) &&
                       (state == S_DONE) && (rd_ptr != count);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= p2;
        if (rd_ok) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            p1 <= '0; p2 <= '0;
            trig_val <= '0; trig_mask <= '0; div_len <= '0; div_cnt <= '0;
            post_len <= '0; post_cnt <= '0;
            wr_ptr <= '0; trig_addr <= '0; count <= '0; rd_ptr <= '0;
            triggered <= 1'b0; wrapped <= 1'b0; read_valid <= 1'b0;
            cmd_error <= 1'b0; read_overrun <= 1'b0;
            force_pend <= 1'b0; rd_pend <= 1'b0; rd_data <= '0;
        end else begin
            p1 <= probe;
            p2 <= p1;
            rd_pend <= rd_ok;
            if (rd_pend) begin
                rd_data    <= ram_q;
                read_valid <= 1'b1;
            end
            if (active) div_cnt <= (div_cnt == 8'd0) ? div_len : div_cnt - 8'd1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_ptr == ADDR_LAST) wrapped <= 1'b1;
                if (count != COUNT_MAX) count <= count + 1'b1;
                if (state == S_ARMED && hit) begin
                    trig_addr  <= wr_ptr;
                    triggered  <= 1'b1;
                    force_pend <= 1'b0;
                    // post count 0 makes the trigger sample the final one
                    if (post_len == 16'd0) state <= S_DONE;
                    else begin
                        post_cnt <= post_len - 16'd1;
                        state    <= S_TRIG;
                    end
                end else if (state == S_TRIG) begin
                    if (post_cnt == 16'd0) state <= S_DONE;
                    else post_cnt <= post_cnt - 16'd1;
                end
            end
            if (command_strobe) begin
                case (command)
                    CMD_ARM: begin
                        trig_val <= regOut0; trig_mask <= regOut1;
                        post_len <= {regOut3, regOut2}; div_len <= regOut4;
                        div_cnt <= '0; wr_ptr <= '0; count <= '0; trig_addr <= '0; rd_ptr <= '0;
                        triggered <= 1'b0; wrapped <= 1'b0; read_valid <= 1'b0;
                        cmd_error <= 1'b0; read_overrun <= 1'b0;
                        force_pend <= 1'b0; rd_pend <= 1'b0;
                        state <= S_ARMED;
                    end
                    CMD_ABORT: begin
                        force_pend <= 1'b0;
                        state <= S_IDLE;
                    end
                    CMD_FORCE: if (state == S_ARMED) force_pend <= 1'b1;
                    CMD_READ_NEXT: begin
                        if (state != S_DONE) cmd_error <= 1'b1;
                        else if (rd_ptr == count) read_overrun <= 1'b1;
                        else begin
                            rd_ptr     <= rd_ptr + 1'b1;
                            read_valid <= 1'b0;
                        end
                    end
                    CMD_RESET_READ: begin
                        rd_ptr <= '0; read_overrun <= 1'b0; read_valid <= 1'b0;
                    end
                    default: cmd_error <= 1'b1;
                endcase
            end
        end
    end

    logic [15:0] rd_ext, trig_ext, cnt_ext;
    assign rd_ext   = 16'(rd_ptr[ADDR_W-1:0]);
    assign trig_ext = 16'(trig_addr);
    assign cnt_ext  = 16'(count);

    assign regIn0 = rd_data;
    assign regIn1 = rd_ext[7:0];
    assign regIn2 = rd_ext[15:8];
    assign regIn3 = trig_ext[7:0];
    assign regIn4 = trig_ext[15:8];
    assign regIn5 = cnt_ext[7:0];
    assign regIn6 = cnt_ext[15:8];
    assign regIn7 = VERSION;
    assign status = {active, read_overrun, cmd_error, read_valid, wrapped,
                     state == S_DONE, triggered, state == S_ARMED};
endmodule

// File: tb/tb_logcap_controller.sv
// tb/tb_logcap_controller.sv - table-driven and randomized capture checks against a sample-list reference model
module tb_logcap_controller;
    localparam int DEPTH = 1024;
    localparam logic [7:0] ARM = 8'h01, ABORT = 8'h02, FORCE = 8'h03, RN = 8'h04;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, command_strobe;
    logic [7:0] probe, command;
    logic [7:0] regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7;
    logic [7:0] regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7, status;

    logcap_controller dut (
        .clk(clk), .reset(reset), .probe(probe),
        .command_strobe(command_strobe), .command(command),
        .regOut0(regOut0), .regOut1(regOut1), .regOut2(regOut2), .regOut3(regOut3),
        .regOut4(regOut4), .regOut5(regOut5), .regOut6(regOut6), .regOut7(regOut7),
        .regIn0(regIn0), .regIn1(regIn1), .regIn2(regIn2), .regIn3(regIn3),
        .regIn4(regIn4), .regIn5(regIn5), .regIn6(regIn6), .regIn7(regIn7),
        .status(status)
    );

    typedef struct {
        logic [7:0] val;
        logic [7:0] msk;
        int post;
        int div;
        int mode;
        int force_at;
        int exp_count;
        int exp_trig;
        int exp_wrap;
    } cap_t;

    int vectors = 0, miscompares = 0;
    int mode = 1;
    logic [7:0] hist[$];
    logic [7:0] exp_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // hist[i] is the probe value driven in the cycle ending at edge i-1 (edge 0 = ARM)
    task automatic step(input logic stb, input logic [7:0] cmd);
        @(negedge clk);
        command_strobe = stb;
        command = cmd;
        case (mode)
            0: probe = 8'h50 + 8'(hist.size());
            1: probe = 8'($urandom);
            default: probe = 8'($urandom) & 8'h7F;
        endcase
        hist.push_back(probe);
    endtask

    // Sample j is hist[j*(div+1)]; capture ends post samples after the first trigger.
    task automatic model(input int d, input logic [7:0] val, input logic [7:0] msk, input int post,
                         input int jforce, output int cnt, output int trig, output int wrp, output bit ok);
        logic [7:0] all[$];
        int total;
        total = -1;
        trig = -1;
        cnt = 0;
        wrp = 0;
        exp_rd.delete();
        for (int j = 0; j * (d + 1) < hist.size() && total < 0; j++) begin
            logic [7:0] s;
            s = hist[j * (d + 1)];
            all.push_back(s);
            if (trig < 0 && ((((s ^ val) & msk) == 8'd0) || (jforce >= 0 && j >= jforce))) trig = j;
            if (trig >= 0 && j == trig + post) total = j + 1;
        end
        ok = (total > 0);
        if (ok) begin
            cnt = (total < DEPTH) ? total : DEPTH;
            wrp = (total >= DEPTH) ? 1 : 0;
            trig = trig % DEPTH;
            for (int k = total - cnt; k < total; k++) exp_rd.push_back(all[k]);
        end
    endtask

    task automatic read_next();
        step(1'b1, RN);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
    endtask

    task automatic run_capture(input cap_t c);
        bit seen, ok;
        int cnt, trig, wrp;
        mode = c.mode;
        regOut0 = c.val; regOut1 = c.msk;
        regOut2 = 8'(c.post); regOut3 = 8'(c.post >> 8); regOut4 = 8'(c.div);
        hist.delete();
        step(1'b0, 8'h00);
        step(1'b1, ARM);
        seen = 1'b0;
        for (int n = 0; n < 5000 && !seen; n++) begin
            if (c.force_at >= 0 && hist.size() == c.force_at) step(1'b1, FORCE);
            else step(1'b0, 8'h00);
            if (status[2]) seen = 1'b1;
        end
        check("done_reached", 32'(seen), 32'd1);
        if (!seen) return;
        model(c.div, c.val, c.msk, c.post, (c.force_at >= 0) ? c.force_at - 1 : -1, cnt, trig, wrp, ok);
        check("model_complete", 32'(ok), 32'd1);
        if (!ok) return;
        check("done_status", 32'(status), {24'd0, 4'b0000, wrp[0], 3'b110});
        check("trig_addr", {16'd0, regIn4, regIn3}, 32'(trig));
        check("count", {16'd0, regIn6, regIn5}, 32'(cnt));
        if (c.exp_count >= 0) begin
            check("tab_count", {16'd0, regIn6, regIn5}, 32'(c.exp_count));
            check("tab_trig", {16'd0, regIn4, regIn3}, 32'(c.exp_trig));
            check("tab_wrap", 32'(status[3]), 32'(c.exp_wrap));
        end
        for (int k = 0; k < cnt; k++) begin
            step(1'b1, RN);
            step(1'b0, 8'h00);
            if (k == 1) check("read_valid_clr", 32'(status[4]), 32'd0);
            step(1'b0, 8'h00);
            check("read_data", 32'(regIn0), 32'(exp_rd[k]));
            if (k == 0) check("read_valid_set", 32'(status[4]), 32'd1);
        end
        check("rd_ptr_lo", 32'(regIn1), 32'(cnt & 8'hFF));
        read_next();
        check("overrun_flag", 32'(status[6]), 32'd1);
        check("overrun_hold", 32'(regIn0), 32'(exp_rd[cnt - 1]));
    endtask

    cap_t tab[4];

    initial begin
        tab[0] = '{val: 8'h5A, msk: 8'hFF, post: 4,    div: 0, mode: 0, force_at: -1,
                   exp_count: 15,   exp_trig: 10,  exp_wrap: 0};
        tab[1] = '{val: 8'h00, msk: 8'h00, post: 2,    div: 3, mode: 0, force_at: -1,
                   exp_count: 3,    exp_trig: 0,   exp_wrap: 0};
        tab[2] = '{val: 8'hFF, msk: 8'hFF, post: 0,    div: 0, mode: 2, force_at: 1200,
                   exp_count: 1024, exp_trig: 175, exp_wrap: 1};
        tab[3] = '{val: 8'h00, msk: 8'h00, post: 1100, div: 0, mode: 1, force_at: -1,
                   exp_count: 1024, exp_trig: 0,   exp_wrap: 1};

        reset = 1'b0; command_strobe = 1'b0; command = 8'h00; probe = 8'h00;
        regOut0 = 0; regOut1 = 0; regOut2 = 0; regOut3 = 0;
        regOut4 = 0; regOut5 = 0; regOut6 = 0; regOut7 = 0;
        repeat (3) @(negedge clk);
        check("rst_status", 32'(status), 32'h00);
        check("rst_version", 32'(regIn7), 32'h01);
        check("rst_regs", {8'd0, regIn0, regIn1, regIn2}, 32'd0);
        check("rst_regs2", {regIn3, regIn4, regIn5, regIn6}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) run_capture(tab[i]);

        for (int r = 0; r < 6; r++) begin
            cap_t c;
            c.val = 8'($urandom);
            c.msk = 8'($urandom & $urandom & $urandom);
            c.post = $urandom_range(0, 40);
            c.div = $urandom_range(0, 3);
            c.mode = 1;
            c.force_at = -1;
            c.exp_count = -1; c.exp_trig = -1; c.exp_wrap = -1;
            run_capture(c);
        end

        // illegal opcodes while ARMED: sticky error, state untouched
        mode = 2;
        regOut0 = 8'hFF; regOut1 = 8'hFF; regOut2 = 8'h00; regOut3 = 8'h00; regOut4 = 8'h00;
        step(1'b0, 8'h00);
        step(1'b1, ARM);
        step(1'b0, 8'h00);
        check("armed_status", 32'(status), 32'h81);
        step(1'b1, 8'h7F);
        step(1'b0, 8'h00);
        check("bad_opcode", 32'(status), 32'hA1);
        step(1'b1, RN);
        step(1'b0, 8'h00);
        check("rn_while_armed", 32'(status), 32'hA1);
        step(1'b1, ARM);
        step(1'b0, 8'h00);
        check("arm_clears_err", 32'(status), 32'h81);
        step(1'b1, ABORT);
        step(1'b0, 8'h00);
        check("abort_idle", 32'(status), 32'h00);

        // reset asserted mid-capture takes effect without a clock edge
        regOut1 = 8'h00; regOut2 = 8'hE8; regOut3 = 8'h03;
        step(1'b1, ARM);
        repeat (5) step(1'b0, 8'h00);
        check("triggered_busy", 32'(status), 32'h82);
        #2 reset = 1'b0;
        #1;
        check("async_rst_status", 32'(status), 32'h00);
        check("async_rst_regs", {regIn3, regIn4, regIn5, regIn6}, 32'd0);
        check("async_rst_ver", 32'(regIn7), 32'h01);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 8'h00);
        step(1'b1, RN);
        step(1'b0, 8'h00);
        check("rn_in_idle", 32'(status), 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
